slice_adder_seq: RTL
====================

Name: slice_adder_seq

Overview:
- Parametrised multi-cycle adder/subtractor for the CPU datapath.
- Processes a WIDTH-bit operand pair SLICE bits per clock, LSB slice first, with a registered carry between slices.
- Uses valid/ready handshakes on input and output, so it sits between the register file and the ALU result mux.
- Trades latency for area on wide words.

Parameters:
- WIDTH, 8, operand and result width in bits.
- SLICE, 4, bits added per clock. WIDTH must be a multiple of SLICE; otherwise elaboration fails.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0.
- sub  input  1  1 selects a + ~b + carry_in; 0 selects a + b + carry_in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result.
- carry_out  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero, negative  output  1 each  present only with SLICE_ADDER_FLAGS_EN.

Behaviour:
- Reset: clk and rst_n are the only clock and reset; reset is synchronous and active-low.
  - rst_n low at an edge forces state IDLE.
  - out_valid=0; sum=0, carry_out=0, overflow=0, zero=0, negative=0.
  - Internal slice counter and carry register cleared.
  - This applies from any state, including mid-RUN: the partial result is discarded and no out_valid follows.
- Constant: NSLICE = WIDTH/SLICE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge: capture a; capture b, or ~b when sub=1; load the carry register with carry_in; set counter=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge adds slice[counter] of A and the effective B plus the carry register.
  - The SLICE result bits are written into sum at position counter*SLICE; the carry register takes the slice carry-out; counter increments.
  - On the edge processing slice NSLICE-1:
    - carry_out is set from the final carry.
    - overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
    - Go to DONE.
- DONE:
  - out_valid=1; in_ready=0.
  - sum, carry_out, overflow (and flags) held stable.
  - On out_ready=1 at an edge: out_valid drops and the state returns to IDLE.
- Latency and throughput:
  - out_valid rises exactly NSLICE cycles after the accepting edge.
  - Minimum issue interval is NSLICE+2 cycles.
  - No acceptance occurs in the same cycle as result hand-off.
- SLICE==WIDTH: single RUN cycle; out_valid rises 1 cycle after accept.
- Output registers change only in RUN. During RUN, sum holds partially updated bits and is valid only while out_valid=1.
- in_valid during RUN/DONE is ignored; the operands are not captured.
- Arithmetic is modulo 2^WIDTH; carry_out is the 2^WIDTH bit.
- With sub=1 and carry_in=1 the result is a-b; carry_out=1 means no borrow.

Optional Feature:
- Macro SLICE_ADDER_FLAGS_EN.
- Defined: ports zero and negative exist and are registered on the final RUN edge.
  - zero=1 iff the full WIDTH result is 0.
  - negative = sum[WIDTH-1].
  - Both are held through DONE and cleared by reset.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package slice_adder_pkg contains:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - function nslice(WIDTH, SLICE).
- Sub-module slice_add (combinational, parameter SLICE) with:
  - inputs a, b, cin;
  - outputs sum, cout, and c_msb (carry into its top bit), which is used for overflow on the last slice.
- Top level holds the FSM, counter, carry register and shift/insert of result slices.

Test Plan:
- W=8,S=4: a=0x0F, b=0x01, cin=0, sub=0 → sum=0x10, cout=0, ovf=0, out_valid exactly 2 cycles after accept.
- W=8,S=4: 0x7F+0x01 → sum=0x80, cout=0, ovf=1, negative=1 (FLAGS_EN). Also 0xFF+0x01 → sum=0x00, cout=1, ovf=0, zero=1.
- W=8,S=4: a=0x05, b=0x07, sub=1, cin=1 → sum=0xFE, cout=0, ovf=0. Also a=0x80, b=0x01, sub=1, cin=1 → sum=0x7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, in_ready stays 0, sum/flags unchanged. Toggling in_valid meanwhile causes no capture.
- Reset mid-RUN: rst_n=0 for one edge after the first slice → next cycle in_ready=1, out_valid=0, all outputs 0. A following 0x12+0x34 gives 0x46.
- W=16,S=4: 0xFFFF+0x0001 → sum=0x0000, cout=1, latency 4. W=8,S=8: 0xA5+0x5A cin=1 → sum=0x00, cout=1, latency 1.

Source files
------------

// File: rtl/slice_adder_pkg.sv
// Shared state encoding and slice-count helper for the slice-serial adder.
package slice_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/slice_add.sv
// Combinational SLICE-bit adder; c_msb is the carry into its top bit, used for signed overflow.
module slice_add #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  assign sum   = full[SLICE-1:0];
  assign cout  = full[SLICE];
  // top sum bit = a ^ b ^ carry-in, so the carry-in falls out by xor
  assign c_msb = a[SLICE-1] ^ b[SLICE-1] ^ full[SLICE-1];

endmodule

// File: rtl/slice_adder_seq.sv
// Slice-serial adder/subtractor: WIDTH bits processed SLICE bits per clock, LSB first.
// Define SLICE_ADDER_FLAGS_EN to add the registered zero/negative result flags.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// RUN   | adding one slice per clock, carry held in carry_q
// DONE  | out_valid=1, result held until out_ready
module slice_adder_seq
  import slice_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
`ifdef SLICE_ADDER_FLAGS_EN
  ,
  output logic             zero,
  output logic             negative
`endif
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  generate
    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("slice_adder_seq: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
`ifdef SLICE_ADDER_FLAGS_EN
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
`endif

  int               base;
  logic [SLICE-1:0] sl_a, sl_b, sl_sum;
  logic             sl_cout, sl_cmsb;

  always_comb begin
    base = int'(cnt_q) * SLICE;
    sl_a = a_q[base +: SLICE];
    sl_b = b_q[base +: SLICE];
  end

  slice_add #(.SLICE(SLICE)) u_slice_add (
    .a     (sl_a),
    .b     (sl_b),
    .cin   (carry_q),
    .sum   (sl_sum),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef SLICE_ADDER_FLAGS_EN
    zero_d  = zero_q;
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = carry_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: SLICE] = sl_sum;
        carry_d = sl_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = sl_cout;
          ovf_d   = sl_cmsb ^ sl_cout;
`ifdef SLICE_ADDER_FLAGS_EN
          zero_d  = (sum_d == '0);
          neg_d   = sum_d[WIDTH-1];
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SLICE_ADDER_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef SLICE_ADDER_FLAGS_EN
      zero_q  <= zero_d;
      neg_q   <= neg_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
`ifdef SLICE_ADDER_FLAGS_EN
  assign zero      = zero_q;
  assign negative  = neg_q;
`endif

endmodule
